// File: rtl/br_fifo_shared_pop_credit_receiver.sv
// Credit-loop receiver: demultiplexes popped entries by FIFO ID into per-FIFO
// staging buffers and returns one pop_credit per dequeued entry.

module br_fifo_shared_pop_credit_receiver_checker #(
    parameter int NumReadPorts = 1,
    parameter int NumFifos     = 2,
    parameter int Width        = 8,
    parameter int BufferDepth  = 2,
    parameter int FifoIdWidth  = 1,
    parameter int CountWidth   = 2
) (
    input logic                                     clk,
    input logic                                     rst,
    input logic                                     pop_sender_in_reset,
    input logic [NumReadPorts-1:0]                  pop_valid,
    input logic [NumReadPorts-1:0][FifoIdWidth-1:0] pop_fifo_id,
    input logic [NumFifos-1:0]                      enq,
    input logic [NumFifos-1:0]                      deq,
    input logic [NumFifos-1:0]                      out_valid,
    input logic [NumFifos-1:0]                      out_ready,
    input logic [NumFifos-1:0][Width-1:0]           out_data,
    input logic [NumFifos-1:0][CountWidth-1:0]      occupancy
);
    logic [NumFifos-1:0]            multi_hit_s;
    logic [NumFifos-1:0]            hold_r;
    logic [NumFifos-1:0][Width-1:0] data_r;

    // Flags any FIFO targeted by two read ports in the same cycle.
    always_comb begin
        multi_hit_s = '0;
        for (int f = 0; f < NumFifos; f++) begin
            for (int p = 0; p < NumReadPorts; p++) begin
                for (int q = p + 1; q < NumReadPorts; q++) begin
                    multi_hit_s[f] = multi_hit_s[f] | (pop_valid[p] & pop_valid[q] &
                        (pop_fifo_id[p] == FifoIdWidth'(f)) & (pop_fifo_id[q] == FifoIdWidth'(f)));
                end
            end
        end
    end

    // Remembers which heads were stalled so their data can be checked next cycle.
    always_ff @(posedge clk) begin
        if (!rst || pop_sender_in_reset) begin
            hold_r <= '0;
        end else begin
            hold_r <= out_valid & ~out_ready;
        end
        data_r <= out_data;
    end

    // Structural invariants of the staging buffers.
    always_ff @(posedge clk) begin
        if (rst && !pop_sender_in_reset) begin
            for (int f = 0; f < NumFifos; f++) begin
                assert (!multi_hit_s[f]);
                assert (!(enq[f] && (occupancy[f] == CountWidth'(BufferDepth)) && !deq[f]));
                assert (occupancy[f] <= CountWidth'(BufferDepth));
                assert (out_valid[f] == (occupancy[f] != '0));
                if (hold_r[f]) begin
                    assert (out_data[f] == data_r[f]);
                end
            end
        end
    end
endmodule

module br_fifo_shared_pop_credit_receiver #(
    parameter int NumReadPorts      = 1,
    parameter int NumFifos          = 2,
    parameter int Width             = 8,
    parameter int BufferDepth       = 2,
    parameter int RegisterPopCredit = 1,
    localparam int FifoIdWidth      = (NumFifos > 1) ? $clog2(NumFifos) : 1,
    localparam int CountWidth       = $clog2(BufferDepth + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     pop_sender_in_reset,
    output logic                                     pop_receiver_in_reset,
    output logic [NumFifos-1:0]                      pop_credit,
    input  logic [NumReadPorts-1:0]                  pop_valid,
    input  logic [NumReadPorts-1:0][FifoIdWidth-1:0] pop_fifo_id,
    input  logic [NumReadPorts-1:0][Width-1:0]       pop_data,
    output logic [NumFifos-1:0]                      out_valid,
    input  logic [NumFifos-1:0]                      out_ready,
    output logic [NumFifos-1:0][Width-1:0]           out_data,
    output logic [NumFifos-1:0][CountWidth-1:0]      occupancy
);
    localparam int PtrWidth = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        // Explicit wrap keeps non-power-of-2 depths inside the buffer.
        if (ptr == PtrWidth'(BufferDepth - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = ptr + PtrWidth'(1);
        end
    endfunction

    logic [NumFifos-1:0]                              enq_s;
    logic [NumFifos-1:0]                              acc_s;
    logic [NumFifos-1:0]                              deq_s;
    logic [NumFifos-1:0]                              valid_nxt_s;
    logic [NumFifos-1:0][Width-1:0]                   wdata_s;
    logic [NumFifos-1:0][CountWidth-1:0]              occ_nxt_s;
    logic [NumFifos-1:0][CountWidth-1:0]              occ_r;
    logic [NumFifos-1:0]                              valid_r;
    logic [NumFifos-1:0][PtrWidth-1:0]                wr_ptr_r;
    logic [NumFifos-1:0][PtrWidth-1:0]                rd_ptr_r;
    logic [NumFifos-1:0][BufferDepth-1:0][Width-1:0]  mem_r;

    assign pop_receiver_in_reset = ~rst;
    assign out_valid             = valid_r;
    assign occupancy             = occ_r;
    assign deq_s = valid_r & out_ready & {NumFifos{rst & ~pop_sender_in_reset}};

    // Routes each valid read port to the FIFO named by its ID.
    always_comb begin
        enq_s   = '0;
        wdata_s = '0;
        for (int f = 0; f < NumFifos; f++) begin
            for (int p = 0; p < NumReadPorts; p++) begin
                enq_s[f]   = enq_s[f] | (pop_valid[p] & ~pop_sender_in_reset &
                                         (pop_fifo_id[p] == FifoIdWidth'(f)));
                wdata_s[f] = (pop_valid[p] && (pop_fifo_id[p] == FifoIdWidth'(f))) ?
                             pop_data[p] : wdata_s[f];
            end
        end
    end

    // Next occupancy; an enqueue into a full buffer is accepted only alongside a dequeue.
    always_comb begin
        acc_s       = '0;
        occ_nxt_s   = occ_r;
        valid_nxt_s = '0;
        for (int f = 0; f < NumFifos; f++) begin
            acc_s[f] = enq_s[f] & ((occ_r[f] != CountWidth'(BufferDepth)) | deq_s[f]);
            case ({acc_s[f], deq_s[f]})
                2'b10:   occ_nxt_s[f] = occ_r[f] + CountWidth'(1);
                2'b01:   occ_nxt_s[f] = occ_r[f] - CountWidth'(1);
                default: occ_nxt_s[f] = occ_r[f];
            endcase
            valid_nxt_s[f] = (occ_nxt_s[f] != '0);
        end
    end

    // Buffer control state; both resets flush every buffer.
    always_ff @(posedge clk) begin
        if (!rst || pop_sender_in_reset) begin
            occ_r    <= '0;
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            occ_r   <= occ_nxt_s;
            valid_r <= valid_nxt_s;
            for (int f = 0; f < NumFifos; f++) begin
                if (acc_s[f]) begin
                    wr_ptr_r[f] <= ptr_inc(wr_ptr_r[f]);
                end
                if (deq_s[f]) begin
                    rd_ptr_r[f] <= ptr_inc(rd_ptr_r[f]);
                end
            end
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        for (int f = 0; f < NumFifos; f++) begin
            if (acc_s[f]) begin
                mem_r[f][wr_ptr_r[f]] <= wdata_s[f];
            end
        end
    end

    // Head of each buffer.
    always_comb begin
        out_data = '0;
        for (int f = 0; f < NumFifos; f++) begin
            out_data[f] = mem_r[f][rd_ptr_r[f]];
        end
    end

    if (RegisterPopCredit != 0) begin : g_credit_reg
        logic [NumFifos-1:0] credit_r;

        // One-cycle delayed credit return, cleared by either reset.
        always_ff @(posedge clk) begin
            if (!rst || pop_sender_in_reset) begin
                credit_r <= '0;
            end else begin
                credit_r <= deq_s;
            end
        end
        assign pop_credit = credit_r;
    end else begin : g_credit_comb
        assign pop_credit = deq_s;
    end

    br_fifo_shared_pop_credit_receiver_checker #(
        .NumReadPorts (NumReadPorts),
        .NumFifos     (NumFifos),
        .Width        (Width),
        .BufferDepth  (BufferDepth),
        .FifoIdWidth  (FifoIdWidth),
        .CountWidth   (CountWidth)
    ) u_checker (
        .clk                 (clk),
        .rst                 (rst),
        .pop_sender_in_reset (pop_sender_in_reset),
        .pop_valid           (pop_valid),
        .pop_fifo_id         (pop_fifo_id),
        .enq                 (enq_s),
        .deq                 (deq_s),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .occupancy           (occupancy)
    );
endmodule

// File: doc/br_fifo_shared_pop_credit_receiver.md
Name: br_fifo_shared_pop_credit_receiver

Overview:
- Receiver stage placed directly downstream of the shared multi-FIFO credit pop controller.
- Consumes the per-read-port pop_valid/pop_fifo_id/pop_data stream and demultiplexes it by FIFO ID into per-FIFO staging buffers.
- Presents a ready/valid interface per logical FIFO.
- Returns one pop_credit pulse per FIFO for each entry dequeued, closing the credit loop back to the controller.

Parameters:
- NumReadPorts, 1: number of incoming read ports; >=1.
- NumFifos, 2: number of logical FIFOs; >=2.
- Width, 8: data width; >=1.
- BufferDepth, 2: entries per FIFO staging buffer; >=1. Must equal the sender's initial credit per FIFO.
- RegisterPopCredit, 1: if 1, pop_credit is registered, adding 1 cycle. If 0, it is combinational from the dequeue handshake.
- FifoIdWidth, clamped_clog2(NumFifos): localparam.
- CountWidth, $clog2(BufferDepth+1): localparam.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- pop_sender_in_reset  input  1  sender is in reset; flush all state.
- pop_receiver_in_reset  output  1  high while rst is asserted (rst==0).
- pop_credit  output  NumFifos  one credit return per FIFO per cycle.
- pop_valid  input  NumReadPorts  incoming entry valid.
- pop_fifo_id  input  NumReadPorts x FifoIdWidth  destination FIFO of each entry.
- pop_data  input  NumReadPorts x Width  entry data.
- out_valid  output  NumFifos  buffer head valid.
- out_ready  input  NumFifos  consumer ready.
- out_data  output  NumFifos x Width  buffer head data.
- occupancy  output  NumFifos x CountWidth  entries held per FIFO.

Behaviour:
- Reset (rst==0, sampled at posedge):
  - All buffers empty.
  - out_valid=0, occupancy=0, pop_credit=0.
  - pop_receiver_in_reset=1. It is combinational from rst and deasserts in the cycle rst goes high.
- pop_sender_in_reset==1 behaves like reset for buffers, occupancy and the credit register.
  - pop_receiver_in_reset is unaffected.
  - Incoming pop_valid is ignored.
- Demux and enqueue:
  - Entry on port p is written to the buffer selected by pop_fifo_id[p].
  - At most one port targets a given FIFO per cycle. This is an integration assertion.
  - No backpressure exists: credit flow guarantees space.
  - Writing to a full buffer without a same-cycle dequeue fires an assertion. The entry is dropped and occupancy saturates.
- Buffer:
  - Circular FIFO per logical FIFO with wr_ptr/rd_ptr wrapping at BufferDepth.
  - Non-power-of-2 depths wrap explicitly from BufferDepth-1 to 0.
  - Enqueue-to-out_valid latency is 1 cycle; there is no combinational bypass.
  - out_data is the stored head entry and is stable while out_valid && !out_ready. This is asserted.
- Dequeue:
  - Handshake is out_valid[i] && out_ready[i].
  - rd_ptr advances and occupancy decrements.
- Simultaneous enqueue and dequeue on the same FIFO:
  - Both take effect and occupancy is unchanged.
  - This is legal when full (occupancy==BufferDepth).
  - A simultaneous enqueue on an empty buffer is not visible until the next cycle.
- Credit return:
  - pop_credit[i] = dequeue handshake[i], delayed 1 cycle when RegisterPopCredit=1.
  - Exactly one credit per dequeued entry.
  - No credit is returned for entries flushed by reset or sender-reset.
- Invariants (asserted):
  - 0 <= occupancy[i] <= BufferDepth.
  - out_valid[i] == (occupancy[i] != 0).
  - Sum of credits returned == sum of dequeues (modulo the register stage).
- Reset mid-operation: all buffered entries are discarded the following cycle and pending registered credits are cleared.
  - The sender resets its credit counters via pop_receiver_in_reset.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst=0 for 3 cycles, then rst=1.
  - Required: pop_receiver_in_reset=1 during reset then 0; out_valid=0; occupancy=0; pop_credit=0 throughout.
- Single entry, FIFO 1 (NumFifos=4, BufferDepth=2, RegisterPopCredit=1):
  - Stimulus: pop_valid=1, pop_fifo_id=1, pop_data=0xA5 at cycle 0; out_ready[1]=1.
  - Required: out_valid[1]=1 with out_data[1]=0xA5 at cycle 1; occupancy[1]=1 at cycle 1 then 0; pop_credit[1]=1 at cycle 2 only.
- Fill and backpressure:
  - Stimulus: enqueue 0x11 then 0x22 to FIFO 0 with out_ready[0]=0.
  - Required: occupancy[0]=2; out_data[0] held at 0x11 for 5 cycles; pop_credit[0]=0.
  - Then raise out_ready: 0x11 and 0x22 drain in order, with two credit pulses on consecutive cycles.
- Full with simultaneous enqueue and dequeue:
  - Stimulus: FIFO 0 full (0x11, 0x22); enqueue 0x33 while dequeuing 0x11.
  - Required: occupancy stays 2; subsequent outputs are 0x22 then 0x33; pointers wrap correctly; no assertion fires.
- Two ports, different FIFOs (NumReadPorts=2):
  - Stimulus: port0 sends FIFO 2 data 0x5A and port1 sends FIFO 3 data 0xC3 in the same cycle.
  - Required: next cycle out_valid[2] and out_valid[3] are both 1 with the correct data; the other FIFOs are unaffected.
- Sender reset mid-operation:
  - Stimulus: FIFOs 0 and 1 hold one entry each; assert pop_sender_in_reset for 1 cycle.
  - Required: next cycle occupancy=0 and out_valid=0 for all FIFOs; no pop_credit pulses; pop_receiver_in_reset stays 0.
